// File: rtl/ysyx_22050550_icache.sv
// ysyx_22050550_icache: direct-mapped blocking I-cache with burst refill and fence.i invalidation.
// Define YSYX_22050550_ICACHE_PERF_EN to build the 64-bit hit/miss counters.
module ysyx_22050550_icache #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_BYTES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Cache_valid,
    input  logic [63:0]       Cache_addr,
    output logic [63:0]       Cache_Data,
    output logic              Cache_DataOk,
    input  logic              fence_i,
    output logic              fence_done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_rlast,
    output logic [63:0]       perf_hit,
    output logic [63:0]       perf_miss
);
    localparam int OFF   = $clog2(LINE_BYTES);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = ADDR_W - IDX - OFF;
    localparam int BEATS = LINE_BYTES / 8;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP, FENCE} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BW-1:0]     cnt_q;
    logic [SETS-1:0]   valid_q;
    logic              fence_done_q;
    logic [TAG-1:0]    tag_q  [SETS];
    logic [63:0]       data_q [SETS][BEATS];

    logic [IDX-1:0] idx;
    logic [TAG-1:0] tag;
    logic [BW-1:0]  bsel;
    logic [63:0]    beat;
    logic           hit;
    logic           last;
    logic           unused_addr;

    assign idx  = addr_q[OFF+IDX-1:OFF];
    assign tag  = addr_q[ADDR_W-1:OFF+IDX];
    assign bsel = BEATS > 1 ? BW'(addr_q >> 3) : '0;
    assign beat = data_q[idx][bsel];
    assign hit  = valid_q[idx] && tag_q[idx] == tag;
    assign last = mem_rlast || cnt_q == BW'(BEATS - 1);

    assign Cache_DataOk = (state_q == LOOKUP && hit) || state_q == RESP;
    assign Cache_Data   = Cache_DataOk ? {32'h0, addr_q[2] ? beat[63:32] : beat[31:0]} : 64'h0;
    assign fence_done   = fence_done_q;
    assign mem_req      = state_q == MISS;
    assign mem_addr     = {addr_q[ADDR_W-1:OFF], OFF'(0)};
    assign unused_addr  = ^{Cache_addr[63:ADDR_W], addr_q[1:0]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            fence_done_q <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
        end else begin
            fence_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // fence_i is still high in the fence_done cycle; that must not start a second fence
                    if (fence_i && !fence_done_q) state_q <= FENCE;
                    else if (Cache_valid) begin
                        addr_q  <= Cache_addr[ADDR_W-1:0];
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: state_q <= hit ? IDLE : MISS;
                MISS: if (mem_gnt) begin
                    cnt_q   <= '0;
                    state_q <= REFILL;
                end
                REFILL: if (mem_rvalid) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        valid_q[idx] <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: state_q <= IDLE;
                FENCE: begin
                    valid_q      <= '0;
                    fence_done_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset && state_q == REFILL && mem_rvalid) begin
            data_q[idx][cnt_q] <= mem_rdata;
            if (last) tag_q[idx] <= tag;
        end
    end

`ifdef YSYX_22050550_ICACHE_PERF_EN
    logic [63:0] perf_hit_q;
    logic [63:0] perf_miss_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) perf_hit_q <= perf_hit_q + 64'd1;
            else perf_miss_q <= perf_miss_q + 64'd1;
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`else
    assign perf_hit  = 64'h0;
    assign perf_miss = 64'h0;
`endif
endmodule

// File: tb/tb_ysyx_22050550_icache.sv
// tb_ysyx_22050550_icache: table vectors, fence/reset corner sequences and random fetches
// checked against a tag/valid model of a 64-set, 16-byte-line direct-mapped cache.
module tb_ysyx_22050550_icache;
    localparam int BEATS = 2;

    logic        clock, reset, Cache_valid, Cache_DataOk, fence_i, fence_done;
    logic        mem_req, mem_gnt, mem_rvalid, mem_rlast;
    logic [63:0] Cache_addr, Cache_Data, mem_rdata, perf_hit, perf_miss;
    logic [31:0] mem_addr;

    ysyx_22050550_icache dut (
        .clock(clock), .reset(reset), .Cache_valid(Cache_valid), .Cache_addr(Cache_addr),
        .Cache_Data(Cache_Data), .Cache_DataOk(Cache_DataOk), .fence_i(fence_i),
        .fence_done(fence_done), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
        .perf_hit(perf_hit), .perf_miss(perf_miss)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] addr;
        bit          hit;
        logic [31:0] data;
        int          lat;
    } vec_t;

    int          checks = 0, errors = 0, req_count = 0, gnt_delay = 2;
    bit          gaps = 0, abort_mode = 0;
    logic [31:0] exp_line = 0;
    logic [63:0] exp_ph = 0, exp_pm = 0;
    bit          mv [64];
    logic [21:0] mt [64];

    function automatic logic [5:0] midx(input logic [63:0] a);
        return a[9:4];
    endfunction

    function automatic logic [21:0] mtag(input logic [63:0] a);
        return a[31:10];
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h8000_0000) return 32'h0000_0413;
        if (w == 32'h8000_0004) return 32'h0000_0297;
        return (w * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_perf(input string nm);
`ifdef YSYX_22050550_ICACHE_PERF_EN
        chk({nm, " perf_hit"}, perf_hit, exp_ph);
        chk({nm, " perf_miss"}, perf_miss, exp_pm);
`else
        chk({nm, " perf_hit"}, perf_hit, 64'h0);
        chk({nm, " perf_miss"}, perf_miss, 64'h0);
`endif
    endtask

    // Memory side: grant after gnt_delay cycles, then stream the line lowest beat first.
    initial begin
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_rlast = 0;
        forever begin
            @(negedge clock);
            if (mem_req) begin
                req_count++;
                chk("mem_addr", mem_addr, exp_line);
                for (int i = 0; i < gnt_delay; i++) begin
                    @(negedge clock);
                    chk("mem_req held", mem_req, 1);
                end
                mem_gnt = 1;
                @(negedge clock);
                mem_gnt = 0;
                for (int b = 0; b < (abort_mode ? 1 : BEATS); b++) begin
                    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock);
                    mem_rvalid = 1;
                    mem_rlast  = (b == BEATS - 1);
                    mem_rdata  = {memword(exp_line + 32'(8 * b + 4)), memword(exp_line + 32'(8 * b))};
                    @(negedge clock);
                    mem_rvalid = 0;
                    mem_rlast  = 0;
                end
                if (abort_mode) begin
                    @(negedge clock);
                    mem_rvalid = 1; mem_rlast = 1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                    @(negedge clock);
                    mem_rvalid = 0; mem_rlast = 0;
                end
            end
        end
    end

    task automatic wait_resp(input logic [63:0] a, input bit exp_hit, input logic [31:0] exp_data,
                             input bit drop, input string nm, output int lat);
        int rc0;
        rc0 = req_count;
        exp_line = {a[31:4], 4'h0};
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (drop && lat == 1) Cache_valid = 0;
            if (!Cache_DataOk && Cache_Data != 64'h0) chk({nm, " data idle"}, Cache_Data, 64'h0);
        end while (!Cache_DataOk && lat < 200);
        Cache_valid = 0;
        chk({nm, " DataOk"}, Cache_DataOk, 1);
        chk({nm, " data"}, Cache_Data, {32'h0, exp_data});
        chk({nm, " refills"}, req_count - rc0, exp_hit ? 0 : 1);
        @(negedge clock);
        chk({nm, " DataOk pulse"}, Cache_DataOk, 0);
        mv[midx(a)] = 1;
        mt[midx(a)] = mtag(a);
        if (exp_hit) exp_ph++;
        else exp_pm++;
    endtask

    task automatic fetch(input logic [63:0] a, input bit exp_hit, input logic [31:0] exp_data,
                         input int exp_lat, input bit drop, input string nm);
        int lat;
        exp_line = {a[31:4], 4'h0};
        @(negedge clock);
        Cache_valid = 1;
        Cache_addr  = a;
        wait_resp(a, exp_hit, exp_data, drop, nm, lat);
        if (exp_lat >= 0) chk({nm, " latency"}, lat, exp_lat);
        else chk({nm, " miss latency min"}, lat >= 3 + BEATS, 1);
    endtask

    task automatic do_fence(input bit with_req, input logic [63:0] a);
        int n, lat;
        bit early;
        n = 0;
        early = 0;
        exp_line = {a[31:4], 4'h0};
        @(negedge clock);
        fence_i = 1; Cache_valid = with_req; Cache_addr = a;
        do begin
            @(negedge clock);
            n++;
            if (Cache_DataOk) early = 1;
        end while (!fence_done && n < 20);
        fence_i = 0;
        chk("fence_done", fence_done, 1);
        chk("fence latency", n, 2);
        chk("fence before fetch", early, 0);
        for (int s = 0; s < 64; s++) mv[s] = 0;
        @(negedge clock);
        chk("fence_done pulse", fence_done, 0);
        if (with_req) wait_resp(a, 0, memword(a[31:0]), 0, "fenced fetch", lat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [8];
        logic [63:0] a;
        logic [31:0] lo;
        bit          h;
        vt[0] = '{64'h0000_0000_8000_0000, 0, 32'h0000_0413, 7};
        vt[1] = '{64'hFFFF_0000_8000_0004, 1, 32'h0000_0297, 1};
        vt[2] = '{64'h0000_0000_8000_000F, 1, memword(32'h8000_000C), 1};
        vt[3] = '{64'h0000_0000_8000_0400, 0, memword(32'h8000_0400), 7};
        vt[4] = '{64'h1234_5678_8000_0000, 0, 32'h0000_0413, 7};
        vt[5] = '{64'h0000_0000_8000_0018, 0, memword(32'h8000_0018), 7};
        vt[6] = '{64'h0000_0000_8000_000A, 1, memword(32'h8000_0008), 1};
        vt[7] = '{64'h0000_0000_8000_0014, 1, memword(32'h8000_0014), 1};
        clock = 0; reset = 0; Cache_valid = 0; Cache_addr = 0; fence_i = 0;
        for (int s = 0; s < 64; s++) mv[s] = 0;
        repeat (3) @(negedge clock);
        chk("reset DataOk", Cache_DataOk, 0);
        chk("reset Data", Cache_Data, 0);
        chk("reset mem_req", mem_req, 0);
        chk("reset fence_done", fence_done, 0);
        chk_perf("reset");
        reset = 1;

        for (int i = 0; i < 8; i++) fetch(vt[i].addr, vt[i].hit, vt[i].data, vt[i].lat, 0, $sformatf("vec%0d", i));
        chk_perf("table");

        do_fence(1, 64'h8000_0000);

        // Reset lands after refill beat 0; a stray beat then arrives while idle.
        exp_line = 32'h8000_1230;
        gnt_delay = 0;
        abort_mode = 1;
        @(negedge clock);
        Cache_valid = 1;
        Cache_addr = 64'h8000_1230;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            if (c == 2) chk("abort mem_req", mem_req, 1);
            if (c == 4) begin
                Cache_valid = 0;
                reset = 0;
            end
            if (c == 5) begin
                reset = 1;
                chk("abort mem_req drop", mem_req, 0);
                chk("abort DataOk", Cache_DataOk, 0);
                chk("abort Data", Cache_Data, 0);
                for (int s = 0; s < 64; s++) mv[s] = 0;
                exp_ph = 0;
                exp_pm = 0;
                chk_perf("abort reset");
            end
            if (c >= 6) begin
                chk("late beat mem_req", mem_req, 0);
                chk("late beat DataOk", Cache_DataOk, 0);
            end
        end
        abort_mode = 0;
        gnt_delay = 1;
        fetch(64'h8000_1230, 0, memword(32'h8000_1230), 6, 0, "after abort");
        fetch(64'h8000_1234, 1, memword(32'h8000_1234), 1, 0, "perf hit1");
        fetch(64'h8000_1238, 1, memword(32'h8000_1238), 1, 0, "perf hit2");
        fetch(64'h8000_123C, 1, memword(32'h8000_123C), 1, 0, "perf hit3");
        chk_perf("perf 1miss 3hit");

        gaps = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) do_fence(0, 64'h0);
            else begin
                lo = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                     | 32'($urandom_range(0, 15));
                a = {32'($urandom), lo};
                gnt_delay = $urandom_range(0, 3);
                h = mv[midx(a)] && mt[midx(a)] == mtag(a);
                fetch(a, h, memword(lo), h ? 1 : -1, $urandom_range(0, 7) == 0, "rand");
            end
        end
        chk_perf("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
